// File: rtl/counter_seq_arbiter_pkg.sv
// Shared FSM state encoding and step constant for the round-robin +/-3 counter arbiter.
package counter_seq_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int STEP = 3;

endpackage

// File: rtl/counter_seq_arbiter_step3_counter.sv
// N-bit counter stepping by +/-STEP per cycle with synchronous clear; updates land on the next edge.
// No flow control: clear wins over increment, increment over decrement.
module step3_counter
    import counter_seq_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [N-1:0] cnt_o
);

    logic [N-1:0] cnt_q, cnt_d;

    // Subtracting STEP is done as adding its one's complement plus one, i.e. ~(STEP-1).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + N'(STEP);
        end else if (dec_i) begin
            cnt_d = cnt_q + ~N'(STEP - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_seq_arbiter.sv
// Round-robin arbiter feeding a shared +/-3 counter: accept -> cnt RUN cycles -> one DONE cycle.
// Requesters wait on req_ready, granted only in IDLE; clr aborts without a done pulse.
module counter_seq_arbiter
    import counter_seq_arbiter_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_dir,
    input  logic [NREQ*CW-1:0]       req_cnt,
    output logic [NREQ-1:0]          req_ready,
    output logic [N-1:0]             out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id
);

    localparam int IW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          dir_q, dir_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] last_q, last_d;

    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] idx;
    logic          gnt_found;
    logic          arb_en;
    logic          accept;
    logic [CW-1:0] sel_cnt;

    // Search starts one past the last grant; NREQ is a power of two so IW-bit wrap is the modulo.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_q + IW'(k);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // rst is folded in so req_ready drops immediately on an asynchronous reset.
    assign arb_en    = rst & ~clr & (state_q == IDLE);
    assign accept    = arb_en & gnt_found;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
    assign sel_cnt   = req_cnt[gnt_idx*CW +: CW];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        id_d    = id_q;
        last_d  = last_q;
        if (clr) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dir_d  = req_dir[gnt_idx];
                        id_d   = gnt_idx;
                        last_d = gnt_idx;
                        if (sel_cnt == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                            rem_d   = sel_cnt;
                        end
                    end
                end
                RUN: begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            id_q    <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    step3_counter #(.N(N)) u_counter (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .inc_i  ((state_q == RUN) & ~dir_q),
        .dec_i  ((state_q == RUN) & dir_q),
        .cnt_o  (out)
    );

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = id_q;

endmodule

// File: doc/counter_seq_arbiter.md
COUNTER_SEQ_ARBITER -- requirements
Module: counter_seq_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, counter width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (power of 2, 2..8).
REQ-003 SHALL have parameter CW, default 4, repeat-count width per command.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of counter and abort of the active command.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester command valid.
REQ-008 SHALL have port req_dir  input  NREQ  per-requester direction: 0 = +3, 1 = -3.
REQ-009 SHALL have port req_cnt  input  NREQ*CW  per-requester step count; requester i occupies bits [i*CW +: CW].
REQ-010 SHALL have port req_ready  output  NREQ  one-hot accept strobe.
REQ-011 SHALL have port out  output  N  shared counter value.
REQ-012 SHALL have port busy  output  1  high while a command is in RUN or DONE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port done_id  output  log2(NREQ)  index of the completed requester, valid while done=1.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE with any req_valid high, SHALL combinationally assert req_ready for exactly one requester, chosen round-robin starting at last_grant+1 (mod NREQ).
REQ-017 A command SHALL be accepted on the edge where req_valid[i]&req_ready[i]=1; dir, cnt and id SHALL be latched on that edge and last_grant SHALL become i.
REQ-018 req_ready SHALL be all-zero in RUN and DONE, and whenever clr=1.
REQ-019 On accept with cnt>0, SHALL enter RUN with remaining=cnt; on accept with cnt=0, SHALL enter DONE directly.
REQ-020 In RUN, SHALL update out to out±3 modulo 2^N on every edge (−3 implemented as adding ~2), decrement remaining, and go to DONE on the edge that applies the last step.
REQ-021 Latency: for a command accepted on edge e, out SHALL update on edges e+1..e+cnt, and done SHALL be high for the single cycle following edge e+cnt (following e when cnt=0).
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; the next acceptance SHALL occur no earlier than the cycle after DONE.
REQ-023 out SHALL hold its value in IDLE and DONE.
REQ-024 clr=1 SHALL, on the next edge, set out=0, discard the active command, go to IDLE, produce no done pulse, and leave last_grant unchanged; clr SHALL take priority over all other events.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a deasserted req_valid SHALL not be granted.

Reset
REQ-026 rst=0 SHALL asynchronously force: state=IDLE, out=0, remaining=0, busy=0, done=0, done_id=0, req_ready=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-027 Reset asserted mid-command SHALL abort the command with no done pulse; operation SHALL resume on the first edge after rst returns high.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the step constant STEP=3.
REQ-029 The counter datapath SHALL be a sub-module step3_counter (N-bit register with clear, hold, +3 and −3 controls); the arbiter and FSM SHALL reside in counter_seq_arbiter.

Verification
REQ-030 out=0, req0 dir=0 cnt=3 -> out 3, 6, 9 on the three edges after accept; done=1, done_id=0 one cycle later; busy=0 afterwards.
REQ-031 out=0, req1 dir=1 cnt=1 -> out=253 (0xFD, wrap); then req1 dir=0 cnt=1 -> out=0.
REQ-032 All four requesters valid, cnt=1, held high -> grant order 0,1,2,3,0; each command occupies 3 cycles (accept, RUN, DONE).
REQ-033 req2 cnt=0 -> done=1 with done_id=2 in the cycle after accept; out unchanged.
REQ-034 clr pulsed during RUN of req0 cnt=5 after two steps (out=6) -> out=0, no done, IDLE; the next grant goes to requester 1.
REQ-035 rst=0 asynchronously mid-RUN -> all outputs 0 immediately, without waiting for a clock edge; after release, requester 0 has first priority.
